// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer family.
package mux_pkg;

  // Channel-selection modes for stream_mux_nto1.
  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Channel-index width. It never drops below one bit, so a 1-channel or
  // 2-channel index always has a legal vector width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_pick.sv
// Rotating-priority encoder. It returns the first asserted request found
// when scanning ptr, ptr+1, ... and wrapping modulo N_CH.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CHW  = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [CHW-1:0]  gnt_idx,
  output logic            gnt_any
);

  // The scan runs from the farthest offset down to offset 0, so the nearest
  // request to ptr is the last one written and therefore wins.
  always_comb begin : p_scan
    int s;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    gnt_any = 1'b0;
    gnt_idx = '0;
    s       = 0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      s = int'(ptr) + j;
      if (s >= N_CH) s = s - N_CH;
      if (req[s]) begin
        gnt_any = 1'b1;
        gnt_idx = CHW'(s);
      end
    end
  end

endmodule

// File: rtl/stream_mux_nto1.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// The source channel comes from sel_i (SEL mode) or from round-robin
// arbitration among the valid channels (RR mode).
module stream_mux_nto1
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8,
  parameter int MODE = MUX_MODE_SEL,
  parameter int CHW  = clog2_min1(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    in_ready,
  input  logic [CHW-1:0]     sel_i,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [CHW-1:0]     out_ch,
  input  logic               out_ready
);

  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic [CHW-1:0]  r_ch;

  logic            w_slot_free;
  logic [CHW-1:0]  w_cand;
  logic            w_cand_ok;
  logic [N_CH-1:0] w_ready;
  logic            w_take;

  // The output slot can take a word when it is empty or is drained this cycle.
  assign w_slot_free = !r_valid | out_ready;

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic [CHW-1:0] r_rr_ptr;
    logic           w_unused_sel;

    assign w_unused_sel = ^sel_i;

    rr_pick #(.N_CH(N_CH), .CHW(CHW)) u_pick (
      .req     (in_valid),
      .ptr     (r_rr_ptr),
      .gnt_idx (w_cand),
      .gnt_any (w_cand_ok)
    );

    // After each transfer the pointer moves one past the winner, so the
    // winner gets the lowest priority on the next scan.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples pre-edge values no matter the statement order.
      if (!rst_n)      r_rr_ptr <= '0;
      else if (w_take) r_rr_ptr <= (w_cand == CHW'(N_CH - 1)) ? '0 : w_cand + 1'b1;
    end
  end else begin : g_sel
    // An out-of-range select names no channel.
    assign w_cand    = sel_i;
    assign w_cand_ok = (32'(sel_i) < N_CH);
  end

  // Only the candidate lane may see ready. Reset masks it so that no input
  // is acknowledged while the block is held in reset.
  always_comb begin
    w_ready = '0;
    if (rst_n && w_slot_free && w_cand_ok) w_ready[w_cand] = 1'b1;
  end

  assign in_ready = w_ready;
  assign w_take   = |(in_valid & w_ready);

  // Output register. A new word loads on a handshake, even when the old word
  // is popped in the same cycle. A pop with no new word clears valid. A word
  // that is held back by the consumer stays frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_data  <= in_data[w_cand*DW +: DW];
      r_ch    <= w_cand;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule
